// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit.
// Contents: FSM state encoding, ALUControl codes, Op / ImmSrc / ResultSrc /
// ALUSrcB constants and the DP / multiply ALU decode helpers.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_EXECMUL = 4'd10,
        S_MULWB   = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_ORR   = 4'b0011;
    localparam logic [3:0] ALU_EOR   = 4'b0100;
    localparam logic [3:0] ALU_MUL   = 4'b0101;
    localparam logic [3:0] ALU_UMULL = 4'b0110;
    localparam logic [3:0] ALU_SMULL = 4'b0111;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] CMD_CMP = 4'b1010;

    function automatic logic [3:0] dp_alu(input logic [3:0] cmd);
        logic [3:0] r;
        case (cmd)
            4'b0100:          r = ALU_ADD;
            4'b0010, 4'b1010: r = ALU_SUB;
            4'b0000:          r = ALU_AND;
            4'b1100:          r = ALU_ORR;
            4'b0001:          r = ALU_EOR;
            default:          r = ALU_ADD;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] mul_alu(input logic [2:0] variant);
        logic [3:0] r;
        case (variant)
            3'b100:  r = ALU_UMULL;
            3'b110:  r = ALU_SMULL;
            default: r = ALU_MUL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
// master: the control unit (consumes Instr/ALUFlags, drives strobes + Flags).
// slave : the datapath side.
interface multicycle_ctrl_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        opMul;
    logic        IsLongMul;
    logic [3:0]  Flags;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
               opMul, IsLongMul, Flags
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl,
               opMul, IsLongMul, Flags
    );
endinterface

// File: rtl/multicycle_ctrl_cond_unit.sv
// Condition unit: architectural NZCV register, CondEx evaluation on the
// stored flags, and masking of flag writes by CondEx.
// Ports: clk, reset (async active-low), cond (Instr[31:28]), alu_flags
// ({N,Z,C,V} from ALU), flag_w ([1] = write NZ, [0] = write CV),
// flags (stored NZCV), cond_ex.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic [3:0] flags,
    output logic       cond_ex
);
    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // 1111 = never
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= RESET_FLAGS;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset main control unit: Moore FSM sequencing each
// instruction and driving all datapath strobes, ALU decode, and the
// condition unit holding NZCV.
// Ports: clk, reset (async active-low), bus (multicycle_ctrl_if.master:
// Instr/ALUFlags in, all control strobes and Flags out).
//
// state   | meaning
// FETCH   | read instr at PC, IR <= mem, PC <= PC+4
// DECODE  | read regs, PC+8 into R15 path, pick class
// MEMADR  | address = Rn +/- imm12
// MEMRD   | data read at computed address
// MEMWB   | load data -> Rd
// MEMWR   | store Rd at computed address
// EXECR   | DP with register operand
// EXECI   | DP with immediate operand
// ALUWB   | ALU result -> Rd (not for CMP)
// BRANCH  | PC <= PC+8 + imm24
// EXECMUL | MUL / UMULL / SMULL in ALU
// MULWB   | multiply result(s) -> regfile
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic              clk,
    input logic              reset,
    multicycle_ctrl_if.master bus
);
    state_t state_q, state_d;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       mul_class, is_long, is_cmp, dp_arith;
    logic [3:0] alu_dp, alu_mul;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic       unused_instr;

    logic pc_write, reg_write, mem_write, ir_write;

    assign op        = bus.Instr[27:26];
    assign funct     = bus.Instr[25:20];
    assign cmd       = bus.Instr[24:21];
    assign mul_class = (op == OP_DP) && (bus.Instr[25:24] == 2'b00) &&
                       (bus.Instr[7:4] == 4'b1001);
    assign is_long   = (bus.Instr[23:21] == 3'b100) || (bus.Instr[23:21] == 3'b110);
    assign is_cmp    = (cmd == CMD_CMP);
    assign alu_dp    = dp_alu(cmd);
    assign alu_mul   = mul_alu(bus.Instr[23:21]);
    assign dp_arith  = (alu_dp == ALU_ADD) || (alu_dp == ALU_SUB);
    assign unused_instr = ^{bus.Instr[19:8], bus.Instr[3:0]};

    cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.Instr[31:28]),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .flags     (bus.Flags),
        .cond_ex   (cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ImmSrc     = IMM_DP;
        bus.ALUControl = ALU_ADD;
        bus.opMul      = 1'b0;
        bus.IsLongMul  = 1'b0;
        flag_w         = 2'b00;

        case (state_q)
            S_FETCH: begin
                ir_write      = 1'b1;
                pc_write      = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                // RA2 <- Rd for memory ops (store data); RA1 <- R15 for branches
                bus.RegSrc    = {op == OP_MEM, op == OP_BR};
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_DP: begin
                        if (mul_class)     state_d = S_EXECMUL;
                        else if (funct[5]) state_d = S_EXECI;
                        else               state_d = S_EXECR;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                bus.ALUControl = alu_dp;
                if (bus.Instr[20] || is_cmp) flag_w = {1'b1, dp_arith};
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = cond_ex & ~is_cmp;
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                bus.ALUSrcB    = SRCB_IMM;
                bus.ImmSrc     = IMM_MEM;
                bus.ALUControl = bus.Instr[23] ? ALU_ADD : ALU_SUB;
                state_d        = bus.Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.AdrSrc = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = cond_ex;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                mem_write  = cond_ex;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                bus.RegSrc    = 2'b01;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ImmSrc    = IMM_BR;
                bus.ResultSrc = RES_ALURESULT;
                pc_write      = cond_ex;
                state_d       = S_FETCH;
            end
            S_EXECMUL: begin
                bus.ALUControl = alu_mul;
                bus.opMul      = 1'b1;
                bus.IsLongMul  = is_long;
                // multiplies only ever touch N and Z
                if (bus.Instr[20]) flag_w = 2'b10;
                state_d = S_MULWB;
            end
            S_MULWB: begin
                bus.opMul     = 1'b1;
                reg_write     = cond_ex;
                bus.IsLongMul = is_long & cond_ex;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are qualified by reset so nothing can write while it is held low,
    // even though the FSM sits in FETCH during reset.
    assign bus.PCWrite  = pc_write  & reset;
    assign bus.IRWrite  = ir_write  & reset;
    assign bus.RegWrite = reg_write & reset;
    assign bus.MemWrite = mem_write & reset;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam logic [3:0] RST_FLAGS = 4'b0000;

    typedef struct packed {
        logic       pcw, rw, mw, irw, adr;
        logic [1:0] regsrc;
        logic       srca;
        logic [1:0] srcb, ress, imms;
        logic [3:0] aluc;
        logic       opmul, islong;
    } ctl_t;

    localparam int C_DP = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_MUL = 4, C_UND = 5;

    logic clk;
    logic reset;
    multicycle_ctrl_if ifc ();

    multicycle_ctrl #(.RESET_FLAGS(RST_FLAGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_mode = 0;   // 0 idle, 1 full compare, 2 reset compare
    ctl_t exp_cur;
    logic [3:0] mflags;
    ctl_t obs [0:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ctl_t dut_vec();
        ctl_t d;
        d.pcw = ifc.PCWrite;  d.rw = ifc.RegWrite; d.mw = ifc.MemWrite;
        d.irw = ifc.IRWrite;  d.adr = ifc.AdrSrc;  d.regsrc = ifc.RegSrc;
        d.srca = ifc.ALUSrcA; d.srcb = ifc.ALUSrcB; d.ress = ifc.ResultSrc;
        d.imms = ifc.ImmSrc;  d.aluc = ifc.ALUControl;
        d.opmul = ifc.opMul;  d.islong = ifc.IsLongMul;
        return d;
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;          4'h1: return !z;
            4'h2: return c;          4'h3: return !c;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return c && !z;    4'h9: return !c || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int cls_of(input logic [31:0] ins);
        if (ins[27:26] == 2'b01) return ins[20] ? C_LD : C_ST;
        if (ins[27:26] == 2'b10) return C_BR;
        if (ins[27:26] == 2'b11) return C_UND;
        if (ins[25:24] == 2'b00 && ins[7:4] == 4'b1001) return C_MUL;
        return C_DP;
    endfunction

    function automatic int len_of(input int cls);
        case (cls)
            C_BR:    return 3;
            C_LD:    return 5;
            C_UND:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] dp_code(input logic [3:0] cmd);
        if (cmd == 4'b0010 || cmd == 4'b1010) return 4'd1;
        if (cmd == 4'b0000) return 4'd2;
        if (cmd == 4'b1100) return 4'd3;
        if (cmd == 4'b0001) return 4'd4;
        return 4'd0;
    endfunction

    function automatic logic is_long(input logic [31:0] ins);
        return ins[23:21] == 3'b100 || ins[23:21] == 3'b110;
    endfunction

    function automatic logic [3:0] mul_code(input logic [31:0] ins);
        if (ins[23:21] == 3'b100) return 4'd6;
        if (ins[23:21] == 3'b110) return 4'd7;
        return 4'd5;
    endfunction

    function automatic ctl_t exp_out(input int cls, input int ph, input logic [31:0] ins, input logic ce);
        ctl_t e;
        e = '0;
        if (ph == 0) begin
            e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.ress = 2'b10;
        end else if (ph == 1) begin
            e.regsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
            e.srca = 1; e.srcb = 2'b10; e.ress = 2'b10;
        end else begin
            case (cls)
                C_DP: if (ph == 2) begin
                          e.srcb = ins[25] ? 2'b01 : 2'b00;
                          e.aluc = dp_code(ins[24:21]);
                      end else e.rw = ce && ins[24:21] != 4'b1010;
                C_LD, C_ST: if (ph == 2) begin
                          e.srcb = 2'b01; e.imms = 2'b01;
                          e.aluc = ins[23] ? 4'd0 : 4'd1;
                      end else if (ph == 3) begin
                          e.adr = 1;
                          if (cls == C_ST) e.mw = ce;
                      end else begin
                          e.ress = 2'b01; e.rw = ce;
                      end
                C_BR: begin
                          e.regsrc = 2'b01; e.srcb = 2'b01; e.imms = 2'b10;
                          e.ress = 2'b10; e.pcw = ce;
                      end
                C_MUL: if (ph == 2) begin
                          e.aluc = mul_code(ins); e.opmul = 1; e.islong = is_long(ins);
                      end else begin
                          e.opmul = 1; e.rw = ce; e.islong = is_long(ins) && ce;
                      end
                default: ;
            endcase
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_mode == 1) begin
            chk("ctl", 32'(dut_vec()), 32'(exp_cur));
            chk("flags", 32'(ifc.Flags), 32'(mflags));
        end else if (exp_mode == 2) begin
            chk("rst_strobes", 32'({ifc.PCWrite, ifc.RegWrite, ifc.MemWrite, ifc.IRWrite}), 32'h0);
            chk("rst_flags", 32'(ifc.Flags), 32'(RST_FLAGS));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_instr(input logic [31:0] ins, input logic [4:0] af, input int rst_ph);
        int cls, n;
        logic ce, s;
        logic [3:0] alu;
        cls = cls_of(ins);
        n = len_of(cls);
        ifc.Instr = ins;
        for (int ph = 0; ph < n; ph++) begin
            ce = cond_ok(ins[31:28], mflags);
            exp_cur = exp_out(cls, ph, ins, ce);
            alu = af[4] ? 4'($urandom) : af[3:0];
            ifc.ALUFlags = alu;
            exp_mode = 1;
            if (ph == rst_ph) begin
                #2;
                chk("pre_rst_memwrite", 32'(ifc.MemWrite), 32'(exp_cur.mw));
                exp_mode = 2;
                reset = 1'b0;
                #1;
                chk("async_memwrite", 32'(ifc.MemWrite), 32'h0);
                chk("async_flags", 32'(ifc.Flags), 32'(RST_FLAGS));
                repeat (2) @(posedge clk);
                #1;
                mflags = RST_FLAGS;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            obs[ph] = dut_vec();
            @(posedge clk);
            #1;
            if (ph == 2 && (cls == C_DP || cls == C_MUL)) begin
                s = ins[20] || (cls == C_DP && ins[24:21] == 4'b1010);
                if (s && ce) begin
                    mflags[3:2] = alu[3:2];
                    if (cls == C_DP && dp_code(ins[24:21]) <= 4'd1) mflags[1:0] = alu[1:0];
                end
            end
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 2) == 0) r[31:28] = 4'hE;
        if (k <= 3) begin
            r[27:26] = 2'b00;
            if (r[25:24] == 2'b00 && r[7:4] == 4'b1001) r[7] = 1'b0;
        end else if (k == 4) begin
            r[27:24] = 4'b0000;
            r[7:4] = 4'b1001;
        end else if (k <= 6) r[27:26] = 2'b01;
        else if (k <= 8) r[27:26] = 2'b10;
        else r[27:26] = 2'b11;
        return r;
    endfunction

    localparam logic [4:0] RND = 5'h10;

    initial begin
        reset = 1'b1;
        ifc.Instr = 32'h0;
        ifc.ALUFlags = 4'h0;
        mflags = RST_FLAGS;
        #1 reset = 1'b0;
        exp_mode = 2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // ADD R2,R0,R1
        run_instr(32'hE0802001, RND, -1);
        chk("first_fetch_pcw_irw", 32'({obs[0].pcw, obs[0].irw}), 32'h3);
        chk("add_aluc", 32'(obs[2].aluc), 32'h0);
        chk("add_wb", 32'({obs[3].rw, obs[3].ress}), 32'h4);
        chk("add_flags_held", 32'(ifc.Flags), 32'h0);
        // SUBS then BEQ taken
        run_instr(32'hE0523002, 5'b00100, -1);
        chk("subs_flags", 32'(ifc.Flags), 32'h4);
        run_instr(32'h0A000001, RND, -1);
        chk("beq_taken", 32'(obs[2].pcw), 32'h1);
        // ADDS clears flags, BEQ not taken
        run_instr(32'hE0902001, 5'b00000, -1);
        run_instr(32'h0A000001, RND, -1);
        chk("beq_not_taken", 32'(obs[2].pcw), 32'h0);
        // LDR / STR
        run_instr(32'hE5904004, RND, -1);
        chk("ldr_memadr", 32'({obs[2].srcb, obs[2].imms}), 32'h5);
        chk("ldr_memrd", 32'(obs[3].adr), 32'h1);
        chk("ldr_memwb", 32'({obs[4].ress, obs[4].rw}), 32'h3);
        run_instr(32'hE5804004, RND, -1);
        chk("str_memwr", 32'(obs[3].mw), 32'h1);
        // MUL / UMULL
        run_instr(32'hE0050291, RND, -1);
        chk("mul_exec", 32'({obs[2].aluc, obs[2].opmul, obs[2].islong}), 32'h16);
        chk("mul_wb", 32'(obs[3].rw), 32'h1);
        run_instr(32'hE0854291, RND, -1);
        chk("umull_exec", 32'({obs[2].aluc, obs[2].islong}), 32'h0D);
        chk("umull_wb_long", 32'(obs[3].islong), 32'h1);
        // Op=11: no writes
        run_instr(32'hEC000000, RND, -1);
        chk("und_decode_nowr", 32'({obs[1].pcw, obs[1].rw, obs[1].mw, obs[1].irw}), 32'h0);
        // Reset during MEMWR with non-reset flags in place
        run_instr(32'hE0523002, 5'b01010, -1);
        chk("cmp_setup_flags", 32'(ifc.Flags), 32'hA);
        run_instr(32'hE5804004, RND, 3);
        run_instr(32'hE0802001, RND, -1);
        chk("post_rst_fetch", 32'({obs[0].pcw, obs[0].irw}), 32'h3);

        for (int i = 0; i < 250; i++) run_instr(gen_instr(), RND, -1);

        exp_mode = 0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control unit for the multicycle ARM-subset core. It sits directly upstream of the datapath, consuming its Instr and ALUFlags. It sequences each instruction through a Moore FSM and drives every datapath control strobe. It also owns the condition-check logic and the architectural NZCV flag register, including MUL/UMULL/SMULL sequencing.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents from the datapath.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- RegWrite  out  1  regfile port-3 write enable.
- MemWrite  out  1  data-memory write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- RegSrc  out  2  [0] selects R15 for RA1; [1] selects Rd for RA2.
- ALUSrcA  out  1  0 = A, 1 = PC.
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  00 = DP imm8, 01 = mem imm12, 10 = branch imm24.
- ALUControl  out  4  ALU operation code.
- opMul  out  1  current instruction is in the multiply class.
- IsLongMul  out  1  long multiply; enables the 64-bit ALUOut capture and the regfile port-4 write.
- Flags  out  4  stored NZCV, for visualisation.

Behaviour:
- Decode fields:
  - Op = Instr[27:26]; Funct = Instr[25:20]; cond = Instr[31:28].
  - MulClass: Op=00, Instr[25:24]=00 and Instr[7:4]=1001.
  - Multiply variant from Instr[23:21]: 000 MUL, 100 UMULL, 110 SMULL; any other value is treated as MUL.
- ALUControl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR.
  - 0101 MUL, 0110 UMULL, 0111 SMULL.
  - The DP cmd field Instr[24:21] maps: 0100→ADD, 0010/1010(CMP)→SUB, 0000→AND, 1100→ORR, 0001→EOR; any other cmd→ADD.
- Condition check: CondEx is evaluated on stored Flags per the ARM cond table (EQ..AL); 1111 is treated as never.
- Reset: state = FETCH; Flags = RESET_FLAGS. While reset is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The first FETCH occurs on the first rising edge after reset deasserts.
- States and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional). Next: DECODE.
  - DECODE: RegSrc selected per class, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (PC+8 feeds R15). Next:
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - MulClass → EXECMUL.
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=00 otherwise → EXECR.
    - Op=11 → FETCH (no writes).
  - EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI), ALUControl from cmd. Next: ALUWB.
  - ALUWB: ResultSrc=00; RegWrite = CondEx AND NOT CMP. Next: FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl = ADD if U=Instr[23] is 1, else SUB. Next: MEMRD if L=Instr[20], else MEMWR.
  - MEMRD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondEx. Next: FETCH.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx. Next: FETCH.
  - BRANCH: ALUSrcA=0 with RA1=R15, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx. Next: FETCH.
  - EXECMUL: ALUSrcA=0, ALUSrcB=00, ALUControl = MUL/UMULL/SMULL; opMul=1; IsLongMul=1 for UMULL/SMULL. Next: MULWB.
  - MULWB: ResultSrc=00, opMul=1, RegWrite=CondEx, IsLongMul = long AND CondEx. Next: FETCH.
- Flag update: on the rising edge leaving EXECR, EXECI or EXECMUL, when S=Instr[20]=1 and CondEx=1 (CMP has an implicit S):
  - ADD/SUB/CMP write NZCV.
  - Logic ops and MUL write NZ only; C and V are held.
- Cycle counts: B = 3; DP, STR and MUL/long multiply = 4; LDR = 5.
- Defaults: every output not listed for a state is 0.
- Async reset mid-instruction: the FSM returns to FETCH immediately and Flags reload; no partial write may complete after reset asserts.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state encoding, a 4-bit enum of 12 states;
  - the ALUControl codes;
  - the Op, ImmSrc and ResultSrc constants.
- One natural sub-module, cond_unit, holds the flag register, the CondEx evaluation and the FlagW masking. The FSM and ALU decoding stay in the top module.

Test Plan:
- Reset low for 3 cycles, then high → state FETCH, Flags=0000, no write strobes during reset; PCWrite=1 and IRWrite=1 on the first post-reset cycle.
- Instr=0xE0802001 (ADD R2,R0,R1) → FETCH→DECODE→EXECR(ALUControl=0000)→ALUWB(RegWrite=1, ResultSrc=00); Flags unchanged; 4 cycles.
- Instr=0xE0523002 (SUBS) with ALUFlags=0100 in EXECR → Flags=0100. Then Instr=0x0A000001 (BEQ) → BRANCH with PCWrite=1. With Flags=0000, BEQ gives PCWrite=0 in BRANCH.
- Instr=0xE5904004 (LDR) → MEMADR(ALUSrcB=01, ImmSrc=01)→MEMRD(AdrSrc=1)→MEMWB(ResultSrc=01, RegWrite=1); 5 cycles. Instr=0xE5804004 (STR) → MEMWR with MemWrite=1.
- Instr=0xE0050291 (MUL) → EXECMUL(ALUControl=0101, opMul=1, IsLongMul=0)→MULWB(RegWrite=1). Instr=0xE0854291 (UMULL) → ALUControl=0110, IsLongMul=1 in both EXECMUL and MULWB.
- Reset asserted during MEMWR → MemWrite drops to 0 asynchronously, state=FETCH; Op=11 instruction → DECODE→FETCH with zero writes.
